// File: rtl/rr_burst_arbiter_if.sv
// rtl/rr_burst_arbiter_if.sv - requester/downstream handshake bundle for rr_burst_arbiter
interface rr_burst_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   last;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           beat;

  modport master (
    output req, last, out_ready,
    input  grant, grant_valid, grant_id, beat
  );

  modport slave (
    input  req, last, out_ready,
    output grant, grant_valid, grant_id, beat
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// rtl/rr_burst_arbiter.sv - round-robin arbiter that locks a grant for a burst of up to MAX_BURST beats
module rr_burst_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  rr_burst_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N);
  localparam int BW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_d;
  logic [IDW-1:0] ptr, ptr_d;
  logic [IDW-1:0] gid, gid_d;
  logic [BW-1:0]  bcnt, bcnt_d;
  logic [N-1:0]   grant, grant_d;

  logic           found;
  logic [IDW-1:0] pick;
  logic           beat;
  logic           release_now;
  logic [IDW-1:0] ptr_after;

  // Wrap-around search starting at ptr; k is reduced mod N so non-power-of-two N stays in range.
  always_comb begin
    int k;
    found = 1'b0;
    pick  = '0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && bus.req[k]) begin
        found = 1'b1;
        pick  = IDW'(k);
      end
    end
  end

  assign beat        = (|grant) & bus.req[gid] & bus.out_ready;
  assign release_now = (state == BUSY) &&
                       (!bus.req[gid] ||
                        (beat && (bus.last[gid] || bcnt == BW'(MAX_BURST - 1))));
  assign ptr_after   = (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    gid_d   = gid;
    bcnt_d  = bcnt;
    grant_d = grant;
    case (state)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gid_d   = pick;
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
          bcnt_d  = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d = IDLE;
          gid_d   = '0;
          grant_d = '0;
          bcnt_d  = '0;
          ptr_d   = ptr_after;
        end else if (beat) begin
          bcnt_d  = bcnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      gid   <= '0;
      bcnt  <= '0;
      grant <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      gid   <= gid_d;
      bcnt  <= bcnt_d;
      grant <= grant_d;
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_valid = |grant;
  assign bus.grant_id    = gid;
  assign bus.beat        = beat;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb/tb_rr_burst_arbiter.sv - directed vector bench for rr_burst_arbiter (N=4, MAX_BURST=8)
module tb_rr_burst_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  rr_burst_arbiter_if #(.N(4), .IDW(2)) bus ();

  rr_burst_arbiter #(.N(4), .MAX_BURST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] g;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Drive inputs mid-cycle, then check the registered grant and combinational beat before the next edge.
  task automatic step(input logic [3:0] rq, input logic [3:0] ls, input logic rd,
                      input logic [3:0] eg, input logic eb, input string name);
    @(negedge clk);
    bus.req       = rq;
    bus.last      = ls;
    bus.out_ready = rd;
    #1;
    chk({name, ".grant"}, 32'(bus.grant), 32'(eg));
    chk({name, ".beat"}, 32'(bus.beat), 32'(eb));
    chk({name, ".valid"}, 32'(bus.grant_valid), 32'(|eg));
    chk({name, ".id"}, 32'(bus.grant_id), 32'(idx_of(eg)));
  endtask

  initial begin
    tests = 0;
    fails = 0;

    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0});
    tbl.push_back('{4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1});
    tbl.push_back('{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1});
    tbl.push_back('{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0});

    rst           = 1'b0;
    bus.req       = 4'b1111;
    bus.last      = 4'b0000;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.grant", 32'(bus.grant), 32'h0);
    chk("reset.valid", 32'(bus.grant_valid), 32'h0);
    chk("reset.id", 32'(bus.grant_id), 32'h0);
    @(negedge clk);
    rst      = 1'b1;
    bus.last = 4'b1111;
    #1;
    chk("release.grant", 32'(bus.grant), 32'h0);

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].last, tbl[i].rdy, tbl[i].g, tbl[i].b, $sformatf("vec%0d", i));
    end

    // Forced release after MAX_BURST beats, then rotation to the other waiting requester.
    step(4'b1010, 4'b0000, 1'b1, 4'b0000, 1'b0, "forced.idle");
    for (int i = 0; i < 8; i++)
      step(4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, $sformatf("forced.beat%0d", i));
    step(4'b1010, 4'b0000, 1'b1, 4'b0000, 1'b0, "forced.bubble");
    step(4'b1010, 4'b0000, 1'b1, 4'b1000, 1'b1, "forced.next");
    step(4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b0, "forced.abort");
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "forced.end");

    // Stall holds grant and count; dropping req aborts and rotates ptr to 1.
    step(4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, "stall.idle");
    step(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, "stall.first");
    for (int i = 0; i < 5; i++) begin
      step(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0, $sformatf("stall.hold%0d", i));
      chk($sformatf("stall.bcnt%0d", i), 32'(dut.bcnt), 32'd1);
    end
    step(4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, "abort.drop");
    step(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "abort.bubble");
    chk("abort.ptr", 32'(dut.ptr), 32'd1);
    step(4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, "abort.idle");
    step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, "abort.next");

    // Asynchronous reset between edges while BUSY.
    step(4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, "arst.idle");
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, "arst.busy");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.grant", 32'(bus.grant), 32'h0);
    chk("arst.valid", 32'(bus.grant_valid), 32'h0);
    chk("arst.id", 32'(bus.grant_id), 32'h0);
    chk("arst.beat", 32'(bus.beat), 32'h0);
    @(negedge clk);
    bus.req  = 4'b1111;
    bus.last = 4'b0000;
    rst      = 1'b1;
    #1;
    chk("arst.release", 32'(bus.grant), 32'h0);
    step(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, "arst.restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
N-requester round-robin arbiter that shares one downstream channel between requesters sending multi-beat bursts. A grant is locked to one requester until its burst ends, it drops its request, or a beat limit is reached. Priority then rotates to the next requester. The block sits between the requester ports and the shared datapath and drives its select and valid controls.

Parameters:
N, 4, number of requesters (N >= 2)
MAX_BURST, 8, maximum beats per grant before forced release (>= 1)
IDW, $clog2(N), width of grant_id (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
req  input  N  per-requester request; held high for the whole burst
last  input  N  per-requester final-beat flag; sampled only on an accepted beat
out_ready  input  1  downstream can accept a beat this cycle
grant  output  N  one-hot registered grant; all zero when idle
grant_valid  output  1  high when grant is non-zero
grant_id  output  IDW  binary index of the granted requester; 0 when idle
beat  output  1  combinational: grant_valid & req[grant_id] & out_ready (beat accepted)

Behaviour:
- Reset is asynchronous and active-low. While rst=0: grant=0, grant_valid=0, grant_id=0, beat counter=0, priority pointer ptr=0, FSM=IDLE. Asserting reset mid-burst aborts the burst immediately.
- State: FSM {IDLE, BUSY}, ptr (IDW bits), beat counter bcnt ($clog2(MAX_BURST+1) bits).
- IDLE:
  - If req != 0, select the first set bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
  - Register the choice into grant and grant_id and go to BUSY. grant appears the cycle after req is seen: 1-cycle latency.
  - If req == 0, stay in IDLE with outputs zero.
- BUSY, granted index g:
  - An accepted beat (beat=1) increments bcnt.
  - Release when any of these holds:
    - (a) beat & last[g];
    - (b) beat & bcnt == MAX_BURST-1, the forced rotation;
    - (c) req[g]=0, an abort; beat is 0 that cycle.
  - On release: the next cycle has grant=0, FSM=IDLE, bcnt=0, ptr=(g+1) mod N.
  - There is exactly one idle bubble cycle between grants.
  - out_ready=0 stalls the burst; grant is held and bcnt is unchanged.
  - Changes on req[k] for k != g are ignored while BUSY.
  - last[g] without beat has no effect.
- Fairness: a requester that keeps req high waits at most (N-1) grants, each of at most MAX_BURST beats.
- ptr wraps from N-1 to 0. Non-power-of-two N must work; no out-of-range index is ever granted.
- grant is always one-hot or zero. grant_id always equals the index of the set grant bit.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 → grant=0, grant_valid=0, grant_id=0. Release reset → the next cycle gives grant=4'b0001.
- Single burst: req=4'b0100, out_ready=1, last[2] high on the 3rd beat → grant=4'b0100 for 3 beats, then one cycle of grant=0, then ptr=3.
- Rotation: req=4'b1111 held, every burst 1 beat (last=1) → grant sequence 0001, 0, 0010, 0, 0100, 0, 1000, 0, 0001.
- Forced release: MAX_BURST=8, req[1] held, last never asserted, out_ready=1 → release after exactly 8 beats. With req[3] also high, the next grant is 4'b1000.
- Stall and abort:
  - Granted requester 0 sees out_ready=0 for 5 cycles → grant held and bcnt frozen.
  - req[0] then drops mid-burst → grant=0 the next cycle and ptr=1.
- Async reset mid-burst: assert rst=0 between clock edges while BUSY → outputs zero immediately without a clock edge. After release, arbitration restarts from ptr=0.
